// File: rtl/mem_stage_lsu.sv
// Memory stage of the dobby RV32IM pipeline: runs loads and stores over a req/gnt/rvalid
// data bus, aligns store lanes, extends load data and registers the writeback result.
module mem_stage_lsu #(
  parameter int W       = 32,
  parameter int R       = 5,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   ex_result,
  input  logic [W-1:0]   ex_data,
  input  logic [R-1:0]   ex_rd,
  input  logic [2:0]     ex_funct3,
  input  logic [1:0]     ex_opcode,
  input  logic [W-1:0]   pc_4,
  output logic           dbus_req,
  output logic           dbus_we,
  output logic [W-1:0]   dbus_addr,
  output logic [W-1:0]   dbus_wdata,
  output logic [W/8-1:0] dbus_be,
  input  logic           dbus_gnt,
  input  logic           dbus_rvalid,
  input  logic [W-1:0]   dbus_rdata,
  output logic           wb_valid,
  output logic [W-1:0]   wb_result,
  output logic [R-1:0]   wb_rd,
  output logic           misalign_err,
  output logic           bus_err,
  output logic [W-1:0]   err_addr
);
  localparam int NB = W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam bit NARROW = (W == 32'sd32);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t          state_r, state_next_s;
  logic [W-1:0]    addr_r, wdata_r;
  logic [NB-1:0]   be_r;
  logic [2:0]      f3_r;
  logic [R-1:0]    rd_r;
  logic            we_r;
  logic [CW-1:0]   cnt_r;
  logic [NB-1:0]   size_mask_s;
  logic [2:0]      align_mask_s;
  logic            illegal_s, misalign_s, accept_s, is_mem_s, last_s, timeout_s, done_s;

  function automatic logic [W-1:0] extend(input logic [W-1:0] f, input logic [2:0] f3);
    logic [W-1:0] m;
    logic         sb;
    case (f3[1:0])
      2'b00:   begin m = W'(8'hFF);         sb = f[7];  end
      2'b01:   begin m = W'(16'hFFFF);      sb = f[15]; end
      2'b10:   begin m = W'(32'hFFFF_FFFF); sb = f[31]; end
      default: begin m = '1;                sb = 1'b0;  end
    endcase
    if (f3[2]) sb = 1'b0;
    return (f & m) | (sb ? ~m : '0);
  endfunction

  // Decode access size and legality of the operation offered by execute
  always_comb begin
    size_mask_s  = '0;
    align_mask_s = 3'b000;
    case (ex_funct3[1:0])
      2'b00:   begin size_mask_s = NB'(8'h01); align_mask_s = 3'b000; end
      2'b01:   begin size_mask_s = NB'(8'h03); align_mask_s = 3'b001; end
      2'b10:   begin size_mask_s = NB'(8'h0F); align_mask_s = 3'b011; end
      default: begin size_mask_s = NB'(8'hFF); align_mask_s = 3'b111; end
    endcase
    illegal_s  = (ex_funct3 == 3'b111) ||
                 (NARROW && ((ex_funct3 == 3'b011) || (ex_funct3 == 3'b110)));
    misalign_s = illegal_s || ((ex_result[2:0] & align_mask_s) != 3'b000);
  end

  assign in_ready  = (state_r == IDLE);
  assign accept_s  = in_valid && (state_r == IDLE);
  assign is_mem_s  = ex_opcode[1] ^ ex_opcode[0];
  assign last_s    = (cnt_r == CW'(TIMEOUT - 32'sd1));
  assign done_s    = (state_r == RESP) && dbus_rvalid;
  // A response in the final counted cycle beats the timeout
  assign timeout_s = last_s && (state_r != IDLE) && !done_s;

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mem_s && !misalign_s) state_next_s = REQ;
        else                                     state_next_s = IDLE;
      end
      REQ: begin
        if (timeout_s)     state_next_s = IDLE;
        else if (dbus_gnt) state_next_s = RESP;
        else               state_next_s = REQ;
      end
      RESP: begin
        if (done_s || timeout_s) state_next_s = IDLE;
        else                     state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bus outputs are driven only while requesting; the request is withdrawn on the timeout cycle
  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_wdata = '0;
    dbus_be    = '0;
    if (state_r == REQ) begin
      dbus_req   = !last_s;
      dbus_we    = we_r;
      dbus_addr  = {addr_r[W-1:OB], {OB{1'b0}}};
      dbus_wdata = wdata_r;
      dbus_be    = be_r;
    end else begin
      dbus_req   = 1'b0;
    end
  end

  // State register and access timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE) cnt_r <= '0;
      else                 cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Latched access fields, writeback and error reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r       <= '0;
      wdata_r      <= '0;
      be_r         <= '0;
      f3_r         <= 3'b000;
      rd_r         <= '0;
      we_r         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      err_addr     <= '0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (accept_s) begin
        if (!is_mem_s) begin
          wb_valid  <= 1'b1;
          wb_result <= ex_opcode[1] ? pc_4 : ex_result;
          wb_rd     <= ex_rd;
        end else if (misalign_s) begin
          misalign_err <= 1'b1;
          err_addr     <= ex_result;
        end else begin
          addr_r  <= ex_result;
          wdata_r <= ex_data << {ex_result[OB-1:0], 3'b000};
          be_r    <= size_mask_s << ex_result[OB-1:0];
          f3_r    <= ex_funct3;
          rd_r    <= ex_rd;
          we_r    <= ex_opcode[0];
        end
      end else if (done_s) begin
        wb_valid  <= 1'b1;
        wb_result <= we_r ? addr_r : extend(dbus_rdata >> {addr_r[OB-1:0], 3'b000}, f3_r);
        wb_rd     <= we_r ? '0 : rd_r;
      end else if (timeout_s) begin
        bus_err  <= 1'b1;
        err_addr <= addr_r;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a W=32 instance for the main scenarios and a W=64
// instance for double-word and upper-word loads.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready;
  logic [31:0] ex_result = '0, ex_data = '0, pc_4 = '0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_opcode = '0;
  logic        dbus_req, dbus_we, dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
  logic [3:0]  dbus_be;
  logic        wb_valid, misalign_err, bus_err;
  logic [31:0] wb_result, err_addr;
  logic [4:0]  wb_rd;

  logic        in_valid64 = 1'b0, in_ready64;
  logic [63:0] ex_result64 = '0, ex_data64 = '0, pc_464 = '0;
  logic [4:0]  ex_rd64 = '0;
  logic [2:0]  ex_funct364 = '0;
  logic [1:0]  ex_opcode64 = '0;
  logic        dbus_req64, dbus_we64, dbus_gnt64 = 1'b0, dbus_rvalid64 = 1'b0;
  logic [63:0] dbus_addr64, dbus_wdata64, dbus_rdata64 = '0;
  logic [7:0]  dbus_be64;
  logic        wb_valid64, misalign_err64, bus_err64;
  logic [63:0] wb_result64, err_addr64;
  logic [4:0]  wb_rd64;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_lsu #(.W(32), .R(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_result(ex_result), .ex_data(ex_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_opcode(ex_opcode), .pc_4(pc_4), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .misalign_err(misalign_err), .bus_err(bus_err), .err_addr(err_addr)
  );

  mem_stage_lsu #(.W(64), .R(5), .TIMEOUT(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .ex_result(ex_result64), .ex_data(ex_data64), .ex_rd(ex_rd64), .ex_funct3(ex_funct364),
    .ex_opcode(ex_opcode64), .pc_4(pc_464), .dbus_req(dbus_req64), .dbus_we(dbus_we64),
    .dbus_addr(dbus_addr64), .dbus_wdata(dbus_wdata64), .dbus_be(dbus_be64),
    .dbus_gnt(dbus_gnt64), .dbus_rvalid(dbus_rvalid64), .dbus_rdata(dbus_rdata64),
    .wb_valid(wb_valid64), .wb_result(wb_result64), .wb_rd(wb_rd64),
    .misalign_err(misalign_err64), .bus_err(bus_err64), .err_addr(err_addr64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one operation to the W=32 instance for exactly one accepting edge
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd);
    ex_opcode = op; ex_funct3 = f3; ex_result = addr; ex_data = data; ex_rd = rd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_dbus_req", dbus_req, 0);
    chk("rst_err_addr", err_addr, 0);
    rst = 1'b0;
    step();

    // ALU passthrough and pc_4 forward
    issue(2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd7);
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_result", wb_result, 32'h1234_5678);
    chk("alu_wb_rd", wb_rd, 7);
    chk("alu_no_req", dbus_req, 0);
    pc_4 = 32'h0000_0044;
    issue(2'b11, 3'b000, 32'h5555_0000, 32'h0, 5'd1);
    chk("pc4_wb_result", wb_result, 32'h0000_0044);
    chk("pc4_wb_valid", wb_valid, 1);
    step();
    chk("pulse_wb_valid", wb_valid, 0);

    // LB sign extend at 0x103
    issue(2'b10, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    chk("lb_req", dbus_req, 1);
    chk("lb_be", dbus_be, 4'h8);
    chk("lb_addr", dbus_addr, 32'h0000_0100);
    chk("lb_we", dbus_we, 0);
    chk("lb_in_ready", in_ready, 0);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80AB_CDEF;
    chk("lb_resp_wb_valid", wb_valid, 0);
    step();
    dbus_rvalid = 1'b0;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_result", wb_result, 32'hFFFF_FF80);
    chk("lb_wb_rd", wb_rd, 5);
    chk("lb_in_ready", in_ready, 1);

    // LBU at the same address
    issue(2'b10, 3'b100, 32'h0000_0103, 32'h0, 5'd6);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1;
    step();
    dbus_rvalid = 1'b0;
    chk("lbu_wb_valid", wb_valid, 1);
    chk("lbu_wb_result", wb_result, 32'h0000_0080);

    // LH sign extend from the upper half
    issue(2'b10, 3'b001, 32'h0000_0012, 32'h0, 5'd9);
    chk("lh_be", dbus_be, 4'hC);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h9876_0001;
    step();
    dbus_rvalid = 1'b0;
    chk("lh_wb_result", wb_result, 32'hFFFF_9876);

    // SH lane alignment with a 3-cycle grant delay
    issue(2'b01, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 5'd3);
    chk("sh_wdata", dbus_wdata, 32'hBEEF_0000);
    chk("sh_be", dbus_be, 4'hC);
    chk("sh_we", dbus_we, 1);
    for (int i = 0; i < 3; i++) begin
      chk("sh_wait_req", dbus_req, 1);
      chk("sh_wait_in_ready", in_ready, 0);
      step();
    end
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    chk("sh_resp_in_ready", in_ready, 0);
    dbus_rvalid = 1'b1;
    step();
    dbus_rvalid = 1'b0;
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_rd", wb_rd, 0);
    chk("sh_wb_result", wb_result, 32'h0000_0022);
    chk("sh_in_ready", in_ready, 1);

    // Misaligned LW and illegal funct3 at W=32
    issue(2'b10, 3'b010, 32'h0000_0041, 32'h0, 5'd2);
    chk("mis_err", misalign_err, 1);
    chk("mis_err_addr", err_addr, 32'h0000_0041);
    chk("mis_no_req", dbus_req, 0);
    chk("mis_no_wb", wb_valid, 0);
    chk("mis_in_ready", in_ready, 1);
    step();
    chk("mis_pulse", misalign_err, 0);
    chk("mis_err_held", err_addr, 32'h0000_0041);
    issue(2'b10, 3'b011, 32'h0000_0080, 32'h0, 5'd2);
    chk("ld32_err", misalign_err, 1);
    chk("ld32_err_addr", err_addr, 32'h0000_0080);
    chk("ld32_no_req", dbus_req, 0);

    // Timeout: rvalid never arrives
    issue(2'b10, 3'b010, 32'h0000_0200, 32'h0, 5'd4);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("to_wait_bus_err", bus_err, 0);
      chk("to_wait_in_ready", in_ready, 0);
      step();
    end
    step();
    chk("to_bus_err", bus_err, 1);
    chk("to_err_addr", err_addr, 32'h0000_0200);
    chk("to_in_ready", in_ready, 1);
    chk("to_req", dbus_req, 0);
    chk("to_no_wb", wb_valid, 0);
    step();
    chk("to_pulse", bus_err, 0);

    // Timeout without grant: request withdrawn in the last counted cycle
    issue(2'b10, 3'b010, 32'h0000_0240, 32'h0, 5'd4);
    for (int i = 0; i < 15; i++) step();
    chk("tog_req_dropped", dbus_req, 0);
    step();
    chk("tog_bus_err", bus_err, 1);
    chk("tog_err_addr", err_addr, 32'h0000_0240);

    // rvalid exactly in the last cycle wins over the timeout
    issue(2'b10, 3'b010, 32'h0000_0300, 32'h0, 5'd8);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("last_in_ready", in_ready, 0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1122_3344;
    step();
    dbus_rvalid = 1'b0;
    chk("last_wb_valid", wb_valid, 1);
    chk("last_bus_err", bus_err, 0);
    chk("last_wb_result", wb_result, 32'h1122_3344);
    chk("last_err_addr", err_addr, 32'h0000_0240);

    // Async reset during REQ and during RESP
    issue(2'b10, 3'b010, 32'h0000_0400, 32'h0, 5'd8);
    chk("rq_req_before", dbus_req, 1);
    rst = 1'b1;
    #1;
    chk("rq_req_reset", dbus_req, 0);
    chk("rq_in_ready_reset", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b10, 3'b010, 32'h0000_0404, 32'h0, 5'd8);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    chk("rs_in_ready_before", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rs_in_ready_reset", in_ready, 1);
    chk("rs_req_reset", dbus_req, 0);
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_F00D;
    step();
    dbus_rvalid = 1'b0;
    chk("rs_late_no_wb", wb_valid, 0);
    chk("rs_late_in_ready", in_ready, 1);

    // W=64: LD at 0x8 returns the full word
    ex_opcode64 = 2'b10; ex_funct364 = 3'b011; ex_result64 = 64'h8; ex_rd64 = 5'd10;
    in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    chk("ld64_be", dbus_be64, 8'hFF);
    chk("ld64_addr", dbus_addr64, 64'h8);
    dbus_gnt64 = 1'b1;
    step();
    dbus_gnt64 = 1'b0; dbus_rvalid64 = 1'b1; dbus_rdata64 = 64'h8877_6655_4433_2211;
    step();
    dbus_rvalid64 = 1'b0;
    chk("ld64_wb_valid", wb_valid64, 1);
    chk("ld64_wb_result", wb_result64, 64'h8877_6655_4433_2211);
    chk("ld64_wb_rd", wb_rd64, 10);

    // W=64: LW from the upper word sign-extends to 64 bits
    ex_funct364 = 3'b010; ex_result64 = 64'h4;
    in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    chk("lw64_be", dbus_be64, 8'hF0);
    chk("lw64_addr", dbus_addr64, 64'h0);
    dbus_gnt64 = 1'b1;
    step();
    dbus_gnt64 = 1'b0; dbus_rvalid64 = 1'b1; dbus_rdata64 = 64'h8000_0000_1234_5678;
    step();
    dbus_rvalid64 = 1'b0;
    chk("lw64_wb_result", wb_result64, 64'hFFFF_FFFF_8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
